// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter that owns the register file write port and tracks pending writes.
// Optional: define WB_CONFLICT_CNT_EN to add a saturating conflict_cnt output.
module regfile_wb_arbiter #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 2,
   parameter int unsigned NUM_REGS = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                alu_req,
   input  logic [ADDR_W-1:0]   alu_addr,
   input  logic [DATA_W-1:0]   alu_data,
   output logic                alu_gnt,
   input  logic                mem_req,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_data,
   output logic                mem_gnt,
   input  logic                rsv_en,
   input  logic [ADDR_W-1:0]   rsv_addr,
   output logic                reg_wr_en,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [DATA_W-1:0]   wr_data,
   output logic [NUM_REGS-1:0] busy
`ifdef WB_CONFLICT_CNT_EN
   ,
   output logic [7:0]          conflict_cnt
`endif
);

   typedef enum logic {LastAlu, LastMem} last_e;

   last_e               last_q;
   logic                reg_wr_en_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [DATA_W-1:0]   wr_data_q;
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic                any_gnt;
   logic [ADDR_W-1:0]   gnt_addr;
   logic [DATA_W-1:0]   gnt_data;

   // Grants are gated by reset so nothing is accepted while the block is held in reset.
   always_comb begin
      alu_gnt  = reset_n & alu_req & (~mem_req | (last_q == LastMem));
      mem_gnt  = reset_n & mem_req & (~alu_req | (last_q == LastAlu));
      any_gnt  = alu_gnt | mem_gnt;
      gnt_addr = alu_gnt ? alu_addr : mem_addr;
      gnt_data = alu_gnt ? alu_data : mem_data;
      busy_d   = busy_q;
      if (any_gnt) busy_d[gnt_addr] = 1'b0;
      // A reservation at the same edge as the clearing write is newer, so it wins.
      if (rsv_en)  busy_d[rsv_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q      <= LastMem;
         reg_wr_en_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= '0;
      end else begin
         reg_wr_en_q <= any_gnt;
         busy_q      <= busy_d;
         if (any_gnt) begin
            wr_addr_q <= gnt_addr;
            wr_data_q <= gnt_data;
            last_q    <= alu_gnt ? LastAlu : LastMem;
         end
      end
   end

   assign reg_wr_en = reg_wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;

`ifdef WB_CONFLICT_CNT_EN
   logic [7:0] conflict_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         conflict_cnt_q <= '0;
      end else if (alu_req && mem_req && (conflict_cnt_q != 8'hFF)) begin
         conflict_cnt_q <= conflict_cnt_q + 8'd1;
      end
   end

   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of grants, write port and scoreboard.
module tb_regfile_wb_arbiter;

   logic       clk;
   logic       reset_n;
   logic       alu_req;
   logic [1:0] alu_addr;
   logic [7:0] alu_data;
   logic       alu_gnt;
   logic       mem_req;
   logic [1:0] mem_addr;
   logic [7:0] mem_data;
   logic       mem_gnt;
   logic       rsv_en;
   logic [1:0] rsv_addr;
   logic       reg_wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] busy;
`ifdef WB_CONFLICT_CNT_EN
   logic [7:0] conflict_cnt;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model state.
   bit       m_alu_was_last;
   bit       m_wr_en;
   bit [1:0] m_wr_addr;
   bit [7:0] m_wr_data;
   bit [3:0] m_busy;
   int       m_cnt;

   regfile_wb_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .alu_req   (alu_req),
      .alu_addr  (alu_addr),
      .alu_data  (alu_data),
      .alu_gnt   (alu_gnt),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_gnt   (mem_gnt),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr),
      .reg_wr_en (reg_wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
`ifdef WB_CONFLICT_CNT_EN
      .busy      (busy),
      .conflict_cnt (conflict_cnt)
`else
      .busy      (busy)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ALU wins when alone, or when both ask and MEM was the last one served.
   function automatic bit mdl_alu_win();
      return alu_req && (!mem_req || !m_alu_was_last);
   endfunction

   function automatic bit mdl_mem_win();
      return mem_req && !(alu_req && (!mem_req || !m_alu_was_last));
   endfunction

   task automatic mdl_reset();
      m_alu_was_last = 1'b0;
      m_wr_en        = 1'b0;
      m_wr_addr      = '0;
      m_wr_data      = '0;
      m_busy         = '0;
      m_cnt          = 0;
   endtask

   // Advance one clock edge and apply the specified effects of that edge to the model.
   task automatic step();
      bit ga, gm, both;
      bit [1:0] aa, ma, ra;
      bit [7:0] ad, md;
      bit re;
      ga = mdl_alu_win();
      gm = mdl_mem_win();
      both = alu_req && mem_req;
      aa = alu_addr; ad = alu_data; ma = mem_addr; md = mem_data;
      re = rsv_en; ra = rsv_addr;
      @(posedge clk);
      if (both && m_cnt < 255) m_cnt++;
      m_wr_en = ga || gm;
      if (ga) begin
         m_wr_addr = aa; m_wr_data = ad; m_busy[aa] = 1'b0; m_alu_was_last = 1'b1;
      end
      if (gm) begin
         m_wr_addr = ma; m_wr_data = md; m_busy[ma] = 1'b0; m_alu_was_last = 1'b0;
      end
      if (re) m_busy[ra] = 1'b1;
      #1;
   endtask

   task automatic clear_inputs();
      alu_req = 0; alu_addr = 0; alu_data = 0;
      mem_req = 0; mem_addr = 0; mem_data = 0;
      rsv_en = 0; rsv_addr = 0;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      clear_inputs();
      mdl_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      alu_req = 1; mem_req = 1;
      mdl_reset();
      #1;
      n_cmp++; if (alu_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_alu_gnt got=%b want=0", alu_gnt); end
      n_cmp++; if (mem_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_mem_gnt got=%b want=0", mem_gnt); end
      n_cmp++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b want=0", reg_wr_en); end
      n_cmp++; if (wr_addr !== 2'd0) begin n_fail++; $display("FAIL reset_wr_addr got=%0d want=0", wr_addr); end
      n_cmp++; if (wr_data !== 8'd0) begin n_fail++; $display("FAIL reset_wr_data got=%h want=00", wr_data); end
      n_cmp++; if (busy !== 4'b0000) begin n_fail++; $display("FAIL reset_busy got=%b want=0000", busy); end
      clear_inputs();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_alu_only();
      apply_reset();
      alu_req = 1; alu_addr = 2'd2; alu_data = 8'h5A;
      #1;
      n_cmp++; if (alu_gnt !== 1'b1) begin n_fail++; $display("FAIL alu_only_gnt got=%b want=1", alu_gnt); end
      n_cmp++; if (mem_gnt !== 1'b0) begin n_fail++; $display("FAIL alu_only_mem_gnt got=%b want=0", mem_gnt); end
      step();
      alu_req = 0;
      n_cmp++; if (reg_wr_en !== 1'b1) begin n_fail++; $display("FAIL alu_only_wr_en got=%b want=1", reg_wr_en); end
      n_cmp++; if (wr_addr !== 2'd2) begin n_fail++; $display("FAIL alu_only_wr_addr got=%0d want=2", wr_addr); end
      n_cmp++; if (wr_data !== 8'h5A) begin n_fail++; $display("FAIL alu_only_wr_data got=%h want=5a", wr_data); end
      step();
      n_cmp++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL alu_only_wr_en_after got=%b want=0", reg_wr_en); end
   endtask

   task automatic test_conflict();
      bit       exp_alu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      bit [7:0] exp_dat [4] = '{8'h11, 8'h33, 8'h11, 8'h33};
      int na = 0;
      int nm = 0;
      apply_reset();
      alu_req = 1; alu_addr = 2'd1; alu_data = 8'h11;
      mem_req = 1; mem_addr = 2'd3; mem_data = 8'h33;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_cmp++;
         if (alu_gnt !== exp_alu[c] || mem_gnt !== !exp_alu[c]) begin
            n_fail++;
            $display("FAIL conflict_gnt[%0d] got alu=%b mem=%b want alu=%b", c, alu_gnt, mem_gnt,
                     exp_alu[c]);
         end
         if (alu_gnt === 1'b1) na++;
         if (mem_gnt === 1'b1) nm++;
         step();
         if (na >= 2) alu_req = 0;
         if (nm >= 2) mem_req = 0;
         n_cmp++;
         if (reg_wr_en !== 1'b1 || wr_data !== exp_dat[c]) begin
            n_fail++;
            $display("FAIL conflict_wr[%0d] got en=%b data=%h want en=1 data=%h", c, reg_wr_en,
                     wr_data, exp_dat[c]);
         end
      end
      alu_req = 0; mem_req = 0;
      step();
      n_cmp++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL conflict_wr_end got=%b want=0", reg_wr_en); end
   endtask

   task automatic test_scoreboard();
      apply_reset();
      rsv_en = 1; rsv_addr = 2'd1;
      step();
      rsv_en = 0;
      n_cmp++; if (busy !== 4'b0010) begin n_fail++; $display("FAIL sb_reserve got=%b want=0010", busy); end
      mem_req = 1; mem_addr = 2'd1; mem_data = 8'hC3;
      rsv_en = 1; rsv_addr = 2'd1;
      #1;
      n_cmp++; if (mem_gnt !== 1'b1) begin n_fail++; $display("FAIL sb_mem_gnt got=%b want=1", mem_gnt); end
      step();
      rsv_en = 0;
      n_cmp++; if (busy !== 4'b0010) begin n_fail++; $display("FAIL sb_set_wins got=%b want=0010", busy); end
      mem_data = 8'hC4;
      step();
      mem_req = 0;
      n_cmp++; if (busy !== 4'b0000) begin n_fail++; $display("FAIL sb_clear got=%b want=0000", busy); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      rsv_en = 1; rsv_addr = 2'd1;
      step();
      rsv_addr = 2'd3;
      alu_req = 1; alu_addr = 2'd0; alu_data = 8'hA5;
      step();
      rsv_en = 0;
      n_cmp++;
      if (reg_wr_en !== 1'b1 || busy !== 4'b1010) begin
         n_fail++;
         $display("FAIL arst_setup got en=%b busy=%b want en=1 busy=1010", reg_wr_en, busy);
      end
      alu_req = 1; mem_req = 1;
      #2;
      reset_n = 1'b0;
      mdl_reset();
      #1;
      n_cmp++;
      if (reg_wr_en !== 1'b0 || wr_addr !== 2'd0 || wr_data !== 8'd0 || busy !== 4'b0000) begin
         n_fail++;
         $display("FAIL arst_outputs got en=%b addr=%0d data=%h busy=%b want all 0", reg_wr_en,
                  wr_addr, wr_data, busy);
      end
      n_cmp++;
      if (alu_gnt !== 1'b0 || mem_gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_gnt got alu=%b mem=%b want 0 0", alu_gnt, mem_gnt);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      n_cmp++;
      if (alu_gnt !== 1'b1 || mem_gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_first_conflict got alu=%b mem=%b want 1 0", alu_gnt, mem_gnt);
      end
      step();
      alu_req = 0; mem_req = 0;
      step();
   endtask

   task automatic test_idle_hold();
      apply_reset();
      alu_req = 1; alu_addr = 2'd3; alu_data = 8'h7F;
      step();
      alu_req = 0;
      n_cmp++; if (reg_wr_en !== 1'b1) begin n_fail++; $display("FAIL idle_grant_wr_en got=%b want=1", reg_wr_en); end
      for (int c = 0; c < 3; c++) begin
         step();
         n_cmp++;
         if (reg_wr_en !== 1'b0 || wr_addr !== 2'd3 || wr_data !== 8'h7F) begin
            n_fail++;
            $display("FAIL idle_hold[%0d] got en=%b addr=%0d data=%h want en=0 addr=3 data=7f", c,
                     reg_wr_en, wr_addr, wr_data);
         end
      end
   endtask

   task automatic test_random();
      bit ga, gm;
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         if (!alu_req && $urandom_range(0, 1) == 1) begin
            alu_req = 1; alu_addr = 2'($urandom_range(0, 3)); alu_data = 8'($urandom);
         end
         if (!mem_req && $urandom_range(0, 1) == 1) begin
            mem_req = 1; mem_addr = 2'($urandom_range(0, 3)); mem_data = 8'($urandom);
         end
         rsv_en   = ($urandom_range(0, 2) == 0);
         rsv_addr = 2'($urandom_range(0, 3));
         #1;
         ga = mdl_alu_win();
         gm = mdl_mem_win();
         n_cmp++;
         if (alu_gnt !== ga || mem_gnt !== gm) begin
            n_fail++;
            $display("FAIL rand_gnt[%0d] got alu=%b mem=%b want alu=%b mem=%b", c, alu_gnt, mem_gnt,
                     ga, gm);
         end
         step();
         if (ga) alu_req = 0;
         if (gm) mem_req = 0;
         n_cmp++;
         if (reg_wr_en !== m_wr_en || wr_addr !== m_wr_addr || wr_data !== m_wr_data ||
             busy !== m_busy) begin
            n_fail++;
            $display("FAIL rand_port[%0d] got en=%b addr=%0d data=%h busy=%b want en=%b addr=%0d data=%h busy=%b",
                     c, reg_wr_en, wr_addr, wr_data, busy, m_wr_en, m_wr_addr, m_wr_data, m_busy);
         end
      end
      clear_inputs();
      step();
   endtask

`ifdef WB_CONFLICT_CNT_EN
   task automatic test_conflict_cnt();
      apply_reset();
      alu_req = 1; mem_req = 1;
      for (int c = 0; c < 300; c++) begin
         alu_data = 8'(c); mem_data = 8'(c + 1);
         step();
         if (c == 100 || c == 299) begin
            n_cmp++;
            if (conflict_cnt !== 8'(m_cnt)) begin
               n_fail++;
               $display("FAIL conflict_cnt[%0d] got=%0d want=%0d", c, conflict_cnt, m_cnt);
            end
         end
      end
      n_cmp++; if (conflict_cnt !== 8'd255) begin n_fail++; $display("FAIL conflict_cnt_sat got=%0d want=255", conflict_cnt); end
      clear_inputs();
      step();
   endtask
`endif

   initial begin
      reset_n = 1'b1;
      clear_inputs();
      mdl_reset();
      test_reset();
      test_alu_only();
      test_conflict();
      test_scoreboard();
      test_async_reset();
      test_idle_hold();
      test_random();
`ifdef WB_CONFLICT_CNT_EN
      test_conflict_cnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
